// File: rtl/mul_nnbit_shift_ctrl_if.sv
// Operand, core-control and result signals between dispatch, controller and multiplier core.
// The slave modport is the controller's view; the master modport is the surrounding environment.
interface mul_nnbit_shift_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      i_valid;
  logic                      o_ready;
  logic [DATA_WIDTH-1:0]     i_num_x;
  logic [DATA_WIDTH-1:0]     i_num_y;
  logic                      o_mul_rst_n;
  logic [DATA_WIDTH-1:0]     o_mul_num_x;
  logic [DATA_WIDTH-1:0]     o_mul_num_y;
  logic                      i_mul_end;
  logic [2*DATA_WIDTH-1:0]   i_mul_res;
  logic                      o_valid;
  logic                      i_ready;
  logic [2*DATA_WIDTH-1:0]   o_res;
  logic                      o_err;
  logic                      o_busy;

  modport slave (
    input  i_valid, i_num_x, i_num_y, i_mul_end, i_mul_res, i_ready,
    output o_ready, o_mul_rst_n, o_mul_num_x, o_mul_num_y, o_valid, o_res, o_err, o_busy
  );

  modport master (
    output i_valid, i_num_x, i_num_y, i_mul_end, i_mul_res, i_ready,
    input  o_ready, o_mul_rst_n, o_mul_num_x, o_mul_num_y, o_valid, o_res, o_err, o_busy
  );
endinterface

// File: rtl/mul_nnbit_shift_ctrl.sv
// Valid/ready front end that loads operands into the shift multiplier core and returns its product.
// Latency: o_valid DATA_WIDTH+3 cycles after the input handshake for a nominal core.
// Backpressure: holds the result in DONE while i_ready=0; accepts new operands only in IDLE.
module mul_nnbit_shift_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 2*DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  mul_nnbit_shift_ctrl_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   x_q;
  logic [DATA_WIDTH-1:0]   y_q;
  logic [2*DATA_WIDTH-1:0] res_q;
  logic                    valid_q;
  logic                    err_q;
  logic                    mul_rst_n_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      mul_rst_n_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            x_q   <= bus.i_num_x;
            y_q   <= bus.i_num_y;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          // Core has sampled the operands under reset; release it for the run.
          mul_rst_n_q <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (bus.i_mul_end) begin
            res_q       <= bus.i_mul_res;
            err_q       <= 1'b0;
            valid_q     <= 1'b1;
            mul_rst_n_q <= 1'b0;
            state       <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            valid_q     <= 1'b1;
            mul_rst_n_q <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready     = (state == IDLE);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_mul_rst_n = mul_rst_n_q;
  assign bus.o_mul_num_x = x_q;
  assign bus.o_mul_num_y = y_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_res       = res_q;
  assign bus.o_err       = err_q;
endmodule

// File: tb/tb_mul_nnbit_shift_ctrl.sv
// Directed bench for mul_nnbit_shift_ctrl with a behavioural shift-multiplier core stub.
module tb_mul_nnbit_shift_ctrl;
  localparam int DW      = 8;
  localparam int TIMEOUT = 2*DW;
  localparam int LAT     = DW + 3;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic stub_dead = 1'b0;

  mul_nnbit_shift_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  mul_nnbit_shift_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Nominal core: end flag on the DW+1th cycle out of reset, product valid only then.
  logic [7:0]         core_cnt;
  logic signed [15:0] core_sx, core_sy;
  always_ff @(posedge clk) begin
    if (!bus.o_mul_rst_n) core_cnt <= '0;
    else                  core_cnt <= core_cnt + 8'd1;
  end
  always_comb begin
    core_sx       = {{DW{bus.o_mul_num_x[DW-1]}}, bus.o_mul_num_x};
    core_sy       = {{DW{bus.o_mul_num_y[DW-1]}}, bus.o_mul_num_y};
    bus.i_mul_end = !stub_dead && bus.o_mul_rst_n && (core_cnt == 8'(DW));
    bus.i_mul_res = bus.i_mul_end ? 16'(core_sx * core_sy) : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.o_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready_wait"}, 32'(bus.o_ready), 32'd1);
  endtask

  // Handshake, measure cycles until o_valid, compare result and confirm single-cycle o_valid.
  task automatic do_txn(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp_res, input logic exp_err, input int exp_lat);
    int lat;
    wait_ready(name);
    bus.i_num_x = x; bus.i_num_y = y; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, 32'(bus.o_res), 32'(exp_res));
    check({name, "_err"}, 32'(bus.o_err), 32'(exp_err));
    @(posedge clk); #1;
    check({name, "_valid_pulse"}, {30'd0, bus.o_valid, bus.o_ready}, 32'b01);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] res;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0]         rx, ry;
    logic signed [15:0] sx, sy;
    logic [15:0]        e;
    logic               seen;
    int                 n, prev;

    vecs[0] = '{"v_3x5",     8'h03, 8'h05, 16'h000F};
    vecs[1] = '{"v_m3x5",    8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{"v_min_min", 8'h80, 8'h80, 16'h4000};
    vecs[3] = '{"v_max_min", 8'h7F, 8'h80, 16'hC080};
    vecs[4] = '{"v_7x6",     8'h07, 8'h06, 16'h002A};
    vecs[5] = '{"v_m1_m1",   8'hFF, 8'hFF, 16'h0001};
    vecs[6] = '{"v_0x7f",    8'h00, 8'h7F, 16'h0000};

    rst_n = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    bus.i_num_x = '0; bus.i_num_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.o_ready, bus.o_busy, bus.o_valid, bus.o_err, bus.o_mul_rst_n, bus.o_res},
          {5'b10000, 16'h0000});
    check("reset_operands", {bus.o_mul_num_x, bus.o_mul_num_y}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      do_txn(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].res, 1'b0, LAT);

    // Backpressure: result held, new operands ignored, handshake returns to IDLE.
    bus.i_ready = 1'b0;
    wait_ready("bp");
    bus.i_num_x = 8'h09; bus.i_num_y = 8'hFE; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    n = 1;
    while (!bus.o_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("bp_latency", 32'(n), 32'(LAT));
    bus.i_num_x = 8'h55; bus.i_num_y = 8'h66; bus.i_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp_hold",
            {bus.o_valid, bus.o_ready, bus.o_err, bus.o_mul_rst_n, bus.o_res, bus.o_mul_num_x},
            {4'b1000, 16'hFFEE, 8'h09});
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {bus.o_valid, bus.o_ready, bus.o_busy}, 32'b010);
    @(posedge clk); #1;
    check("bp_accept_later", {bus.o_busy, bus.o_mul_num_x, bus.o_mul_num_y}, {1'b1, 8'h55, 8'h66});
    bus.i_valid = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("bp_next_res", 32'(bus.o_res), 32'h21DE);
    @(posedge clk); #1;

    // Timeout with a dead core, then recovery with the working core.
    stub_dead = 1'b1;
    do_txn("timeout", 8'h03, 8'h05, 16'h0000, 1'b1, TIMEOUT + 2);
    stub_dead = 1'b0;
    do_txn("after_timeout", 8'h03, 8'h05, 16'h000F, 1'b0, LAT);

    // Reset pulse on the fourth RUN cycle discards the transaction.
    wait_ready("midrst");
    bus.i_num_x = 8'h02; bus.i_num_y = 8'h03; bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_in_run", {bus.o_busy, bus.o_mul_rst_n}, 32'b11);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_state",
          {bus.o_busy, bus.o_mul_rst_n, bus.o_valid, bus.o_ready, bus.o_mul_num_x},
          {4'b0001, 8'h00});
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.o_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    do_txn("midrst_7x6", 8'h07, 8'h06, 16'h002A, 1'b0, LAT);

    // Back-to-back random operands with i_valid and i_ready held high.
    prev = 0;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      sx = {{8{rx[7]}}, rx}; sy = {{8{ry[7]}}, ry};
      e  = sx * sy;
      bus.i_num_x = rx; bus.i_num_y = ry;
      n = 0;
      while (!bus.o_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      n = 0;
      while (!bus.o_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      check("b2b_res", 32'(bus.o_res), 32'(e));
      if (i > 0) check("b2b_spacing", 32'(cyc - prev), 32'(DW + 4));
      prev = cyc;
    end
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
